// File: rtl/tmip_src.sv
// tmip_src: frame source for a TMIP block -- streams one image, then a short action list.
// Optional WAIT_OUT watchdog is enabled by defining TMIP_SRC_TIMEOUT_EN.
module tmip_src #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 3000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   cfg_size,
  input  logic [2:0]   cfg_act_num,
  input  logic [23:0]  cfg_actions,
  input  logic [143:0] cfg_tpl,
  input  logic         pix_valid,
  input  logic [15:0]  pix_data,
  output logic         pix_ready,
  output logic         in_valid,
  output logic         in_valid_2,
  output logic [15:0]  image,
  output logic [15:0]  template,
  output logic [4:0]   img_size,
  output logic [2:0]   action,
  input  logic         out_valid,
  output logic         busy,
  output logic         done,
  output logic         err_cfg,
  output logic         err_gap,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_IMG, ST_GAP, ST_ACT, ST_WAIT_OUT, ST_FIN
  } state_t;

  // One shared counter covers the GAP length, the action index and the watchdog.
  localparam int CW = $clog2(TIMEOUT + GAP + 16);

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [8:0]     r_beat, r_total;
  logic [4:0]     r_size;
  logic [2:0]     r_act_num;
  logic [23:0]    r_actions;
  logic [143:0]   r_tpl;
  logic           r_seen;
  logic           w_size_ok, w_accept, w_last_beat, w_timeout_hit;
  logic [8:0]     w_total;

  assign w_size_ok   = (cfg_size == 5'd4) || (cfg_size == 5'd8) || (cfg_size == 5'd16);
  assign w_total     = 9'(cfg_size) * 9'(cfg_size);
  assign pix_ready   = (r_state == ST_IMG);
  assign w_accept    = pix_ready & pix_valid;
  assign w_last_beat = w_accept && (r_beat == r_total - 9'd1);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (start && w_size_ok) w_next = ST_IMG;
      ST_IMG:      if (w_last_beat) w_next = ST_GAP;
      ST_GAP:      if (r_cnt == CW'(GAP - 1)) w_next = ST_ACT;
      ST_ACT:      if (r_cnt == CW'(r_act_num)) w_next = ST_WAIT_OUT;
      ST_WAIT_OUT: if ((r_seen && !out_valid) || w_timeout_hit) w_next = ST_FIN;
      ST_FIN:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Template words and actions are consumed by shifting, so exhausted words read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_beat     <= '0;
      r_total    <= '0;
      r_size     <= '0;
      r_act_num  <= '0;
      r_actions  <= '0;
      r_tpl      <= '0;
      r_seen     <= 1'b0;
      in_valid   <= 1'b0;
      in_valid_2 <= 1'b0;
      image      <= '0;
      template   <= '0;
      img_size   <= '0;
      action     <= '0;
      err_cfg    <= 1'b0;
      err_gap    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      r_cnt      <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      in_valid   <= 1'b0;
      in_valid_2 <= 1'b0;
      image      <= '0;
      template   <= '0;
      img_size   <= '0;
      action     <= '0;
      err_cfg    <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (start) begin
          err_gap <= 1'b0;
          err_cfg <= !w_size_ok;
          if (w_size_ok) begin
            r_size    <= cfg_size;
            r_total   <= w_total;
            r_act_num <= cfg_act_num;
            r_actions <= cfg_actions;
            r_tpl     <= cfg_tpl;
            r_beat    <= '0;
          end
        end
        ST_IMG: if (w_accept) begin
          in_valid <= 1'b1;
          image    <= pix_data;
          template <= r_tpl[15:0];
          r_tpl    <= r_tpl >> 16;
          img_size <= (r_beat == 9'd0) ? r_size : 5'd0;
          r_beat   <= r_beat + 9'd1;
        end else if (r_beat != 9'd0) begin
          err_gap <= 1'b1;
        end
        ST_ACT: begin
          in_valid_2 <= 1'b1;
          action     <= r_actions[2:0];
          r_actions  <= r_actions >> 3;
          r_seen     <= 1'b0;
        end
        ST_WAIT_OUT: if (out_valid) r_seen <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TMIP_SRC_TIMEOUT_EN
  logic r_to;

  assign w_timeout_hit = (r_state == ST_WAIT_OUT) && !r_seen && !out_valid &&
                         (r_cnt == CW'(TIMEOUT - 1));
  assign err_timeout   = (r_state == ST_FIN) && r_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_to <= 1'b0;
    else if (r_state == ST_WAIT_OUT)  r_to <= w_timeout_hit;
  end
`else
  assign w_timeout_hit = 1'b0;
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_tmip_src.sv
// tb_tmip_src: randomized frames checked against a transaction-level model of the
// expected TMIP bus (beat list, template/size rules, gap length, action list, done timing).
module tb_tmip_src;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   cfg_size = '0;
  logic [2:0]   cfg_act_num = '0;
  logic [23:0]  cfg_actions = '0;
  logic [143:0] cfg_tpl = '0;
  logic         pix_valid = 1'b0;
  logic [15:0]  pix_data = '0;
  logic         out_valid = 1'b0;
  logic         pix_ready, in_valid, in_valid_2, busy, done, err_cfg, err_gap, err_timeout;
  logic [15:0]  image, template;
  logic [4:0]   img_size;
  logic [2:0]   action;
  logic [47:0]  all_outs;

  tmip_src #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_size(cfg_size),
    .cfg_act_num(cfg_act_num), .cfg_actions(cfg_actions), .cfg_tpl(cfg_tpl),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .in_valid(in_valid), .in_valid_2(in_valid_2), .image(image), .template(template),
    .img_size(img_size), .action(action), .out_valid(out_valid), .busy(busy),
    .done(done), .err_cfg(err_cfg), .err_gap(err_gap), .err_timeout(err_timeout)
  );

  assign all_outs = {pix_ready, in_valid, in_valid_2, image, template, img_size, action,
                     busy, done, err_cfg, err_gap, err_timeout};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: records the observed bus as transactions.
  int          n_iv, n_iv2, first_iv, last_iv, first_iv2, last_iv2;
  int          n_done, done_cyc, n_to, to_cyc, n_bad;
  logic [15:0] q_img[$], q_tpl[$];
  logic [4:0]  q_sz[$];
  logic [2:0]  q_act[$];

  task automatic clear_mon();
    n_iv = 0; n_iv2 = 0; first_iv = -1; last_iv = -1; first_iv2 = -1; last_iv2 = -1;
    n_done = 0; done_cyc = -1; n_to = 0; to_cyc = -1; n_bad = 0;
    q_img.delete(); q_tpl.delete(); q_sz.delete(); q_act.delete();
  endtask

  always @(negedge clk) begin
    if (in_valid) begin
      if (n_iv == 0) first_iv = cyc;
      last_iv = cyc;
      n_iv++;
      q_img.push_back(image); q_tpl.push_back(template); q_sz.push_back(img_size);
    end else if (image != 0 || template != 0 || img_size != 0) n_bad++;
    if (in_valid_2) begin
      if (n_iv2 == 0) first_iv2 = cyc;
      last_iv2 = cyc;
      n_iv2++;
      q_act.push_back(action);
    end else if (action != 0) n_bad++;
    if (in_valid && in_valid_2) n_bad++;
    if (err_cfg) n_bad++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (err_timeout) begin n_to++; to_cyc = cyc; end
  end

  function automatic logic [143:0] rand_tpl();
    return {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic finish_out();
    int d, h, fall_cyc;
    d = $urandom_range(0, 4);
    h = $urandom_range(1, 3);
    for (int i = 0; i < d; i++) begin @(posedge clk); #1; end
    out_valid = 1'b1;
    for (int i = 0; i < h; i++) begin @(posedge clk); #1; end
    out_valid = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("done_count", n_done, 1);
    check("done_cycle", done_cyc, fall_cyc + 1);
    check("timeout_quiet", n_to, 0);
    check("idle_after_done", busy, 1'b0);
  endtask

  // mode 0: normal, 1: reset during ACT, 2: out_valid held low
  task automatic run_frame(input logic [4:0] size, input logic [2:0] an, input logic [23:0] acts,
                           input logic [143:0] tpl, input int hole_at, input int holes_max,
                           input int mode);
    logic [15:0] pix[$];
    int n, nxt, holes, budget;
    n = int'(size) * int'(size);
    for (int i = 0; i < n; i++) pix.push_back(16'($urandom));
    clear_mon();
    cfg_size = size; cfg_act_num = an; cfg_actions = acts; cfg_tpl = tpl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_size = 5'($urandom); cfg_act_num = 3'($urandom);
    cfg_actions = 24'($urandom); cfg_tpl = ~tpl;
    check("busy_after_start", busy, 1'b1);
    nxt = 0; holes = 0; budget = 0;
    while (nxt < n && budget < 3000) begin
      start = (nxt == 2);
      pix_valid = 1'b0;
      pix_data = 16'h0;
      if (pix_ready) begin
        if (nxt > 0 && holes < holes_max &&
            (hole_at < 0 ? ($urandom_range(0, 3) == 0) : (nxt == hole_at))) begin
          holes++;
          pix_data = 16'($urandom);
        end else begin
          pix_valid = 1'b1;
          pix_data = pix[nxt];
          nxt++;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    check("beats_accepted", nxt, n);

    if (mode == 1) begin
      budget = 0;
      while (!in_valid_2 && budget < 100) begin @(posedge clk); #1; budget++; end
      check("act_reached", in_valid_2, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("outs_async_reset", all_outs, 48'h0);
      @(posedge clk); @(posedge clk); #1;
      check("outs_held_reset", all_outs, 48'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("no_done_after_abort", n_done, 0);
      check("idle_after_abort", busy, 1'b0);
      return;
    end

    budget = 0;
    while (n_iv2 < int'(an) + 1 && budget < 100) begin @(posedge clk); #1; budget++; end
    if (mode == 2) begin
`ifdef TMIP_SRC_TIMEOUT_EN
      budget = 0;
      while (n_done == 0 && budget < TIMEOUT + 20) begin @(posedge clk); #1; budget++; end
      @(posedge clk); #1;
      check("timeout_done_count", n_done, 1);
      check("timeout_done_cycle", done_cyc, last_iv2 + TIMEOUT);
      check("timeout_err_count", n_to, 1);
      check("timeout_err_cycle", to_cyc, last_iv2 + TIMEOUT);
      check("idle_after_timeout", busy, 1'b0);
`else
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; end
      check("wait_no_done", n_done, 0);
      check("wait_still_busy", busy, 1'b1);
      check("wait_no_timeout", n_to, 0);
      finish_out();
`endif
    end else begin
      finish_out();
    end

    check("iv_count", n_iv, n);
    for (int i = 0; i < n && i < q_img.size(); i++) begin
      check("image", q_img[i], pix[i]);
      check("template", q_tpl[i], (i < 9) ? 16'(tpl >> (16 * i)) : 16'h0);
      check("img_size", q_sz[i], (i == 0) ? size : 5'd0);
    end
    check("iv_holes", last_iv - first_iv + 1 - n_iv, holes);
    check("gap_cycles", first_iv2 - last_iv - 1, GAP);
    check("act_count", n_iv2, int'(an) + 1);
    check("act_contiguous", last_iv2 - first_iv2 + 1, n_iv2);
    for (int i = 0; i < q_act.size() && i < 8; i++)
      check("action", q_act[i], 3'(acts >> (3 * i)));
    check("err_gap", err_gap, holes > 0);
    check("bus_hygiene", n_bad, 0);
  endtask

  task automatic illegal_start(input logic [4:0] size);
    cfg_size = size;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_cfg_pulse", err_cfg, 1'b1);
    check("busy_illegal", busy, 1'b0);
    check("ready_illegal", pix_ready, 1'b0);
    @(posedge clk); #1;
    check("err_cfg_clear", err_cfg, 1'b0);
    check("still_idle", busy, 1'b0);
  endtask

  initial begin
    logic [143:0] tpl_seq;
    logic [4:0]   illegal_sizes[5];
    illegal_sizes = '{5'd5, 5'd0, 5'd12, 5'd31, 5'd3};
    for (int k = 0; k < 9; k++) tpl_seq[16 * k +: 16] = 16'(k);

    #2 check("reset_outs", all_outs, 48'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle_after_reset", all_outs, 48'h0);
    @(posedge clk); #1;

    run_frame(5'd4, 3'd1, 24'd1, tpl_seq, -1, 0, 0);
    run_frame(5'd16, 3'd7, 24'($urandom), rand_tpl(), -1, 0, 0);
    foreach (illegal_sizes[i]) illegal_start(illegal_sizes[i]);
    run_frame(5'd4, 3'($urandom), 24'($urandom), rand_tpl(), 10, 3, 0);
    run_frame(5'd8, 3'($urandom), 24'($urandom), rand_tpl(), -1, 0, 0);
    run_frame(5'd8, 3'($urandom_range(3, 7)), 24'($urandom), rand_tpl(), -1, 0, 1);
    run_frame(5'd4, 3'($urandom), 24'($urandom), rand_tpl(), -1, 0, 0);
    run_frame(5'd4, 3'($urandom), 24'($urandom), rand_tpl(), -1, 0, 2);
    for (int r = 0; r < 6; r++)
      run_frame(5'(4 << $urandom_range(0, 2)), 3'($urandom), 24'($urandom), rand_tpl(),
                -1, $urandom_range(0, 5), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
